// File: rtl/axis2fifo_pkg.sv
// Shared state encoding, lane constants and elaboration helpers for the AXIS-to-FIFO packer.
package axis2fifo_pkg;

    localparam int unsigned LANES        = 4;
    localparam int unsigned IDXW         = 2;
    localparam int unsigned PIX_PER_BEAT = 4;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned bpl_of(input int unsigned pixels_h);
        return pixels_h / PIX_PER_BEAT;
    endfunction

    function automatic bit width_ok(input int unsigned fdw, input int unsigned adw);
        return fdw == LANES * adw;
    endfunction

endpackage

// File: rtl/axis2fifo_lane_pack.sv
// Combinational lane inserter: places one beat into its MSB-first lane, keeps earlier lanes, zeroes later ones.
// With AXIS2FIFO_TSTRB_MASK_EN defined, bytes with a cleared TSTRB bit are written as zero.
module axis2fifo_lane_pack
    import axis2fifo_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [LANES*DW-1:0] part,
    input  logic [DW-1:0]       data,
    input  logic [DW/8-1:0]     strb,
    input  logic [IDXW-1:0]     idx,
    output logic [LANES*DW-1:0] word_c
);

    logic [DW-1:0] lane_data;

`ifdef AXIS2FIFO_TSTRB_MASK_EN
    always_comb begin
        lane_data = data;
        for (int b = 0; b < int'(DW / 8); b++) begin
            if (!strb[b]) lane_data[b*8 +: 8] = 8'h00;
        end
    end
`else
    logic strb_unused;
    assign strb_unused = ^strb;
    assign lane_data   = data;
`endif

    // Lanes above idx stay zero, which also provides the zero-fill on an early TLAST.
    always_comb begin
        word_c = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            if (l < int'(idx)) begin
                word_c[(int'(LANES)-1-l)*int'(DW) +: DW] = part[(int'(LANES)-1-l)*int'(DW) +: DW];
            end else if (l == int'(idx)) begin
                word_c[(int'(LANES)-1-l)*int'(DW) +: DW] = lane_data;
            end
        end
    end

endmodule

// File: rtl/axis2fifo.sv
// AXI4-Stream video receiver: packs four 32-bit beats into one FIFO word, tracks line/frame, flags TLAST errors.
// Optional byte masking by TSTRB is enabled with AXIS2FIFO_TSTRB_MASK_EN.
module axis2fifo
    import axis2fifo_pkg::*;
#(
    parameter int unsigned FDW               = 128,
    parameter int unsigned FAW               = 8,
    parameter int unsigned AXIS_DATA_WIDTH   = 32,
    parameter int unsigned PIXELS_HORIZONTAL = 1280,
    parameter int unsigned PIXELS_VERTICAL   = 1024
) (
    input  logic                         S_AXIS_ACLK,
    input  logic                         S_AXIS_ARESETN,
    input  logic                         S_AXIS_TVALID,
    output logic                         S_AXIS_TREADY,
    input  logic [AXIS_DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [AXIS_DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                         S_AXIS_TLAST,
    output logic                         fwr_vld,
    input  logic                         fwr_rdy,
    output logic [FDW-1:0]               fwr_dout,
    input  logic [FAW:0]                 fwr_cnt,
    output logic [10:0]                  line_cnt,
    output logic                         frame_done,
    output logic                         err_tlast
);

    localparam int unsigned BPL       = bpl_of(PIXELS_HORIZONTAL);
    localparam int unsigned BCW       = (BPL > 1) ? $clog2(BPL) : 1;
    localparam logic [10:0] LINE_LAST = 11'(PIXELS_VERTICAL - 1);

    if (!width_ok(FDW, AXIS_DATA_WIDTH) || (BPL % LANES) != 0) begin : g_cfg_err
        $error("axis2fifo: FDW must be 4*AXIS_DATA_WIDTH and PIXELS_HORIZONTAL/4 a multiple of 4");
    end

    logic clk;
    logic rst_n;
    assign clk   = S_AXIS_ACLK;
    assign rst_n = S_AXIS_ARESETN;

    logic fwr_cnt_unused;
    assign fwr_cnt_unused = ^fwr_cnt;

    state_t            state_q,    state_d;
    logic [IDXW-1:0]   beat_idx_q, beat_idx_d;
    logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [FDW-1:0]    part_q,     part_d;
    logic              vld_q,      vld_d;
    logic [FDW-1:0]    dout_q,     dout_d;
    logic [10:0]       line_q,     line_d;
    logic              frame_q,    frame_d;
    logic              err_q,      err_d;
    logic              rdy_en_q;

    logic              stall_c;
    logic              tready_c;
    logic              accept_c;
    logic              cnt_last_c;
    logic              line_end_c;
    logic [FDW-1:0]    word_c;

    // Any committing beat (4th lane or TLAST) waits while the previous word is still pending.
    assign stall_c    = vld_q && !fwr_rdy && ((beat_idx_q == IDXW'(LANES - 1)) || S_AXIS_TLAST);
    assign tready_c   = rdy_en_q && ((state_q == SYNC) || !stall_c);
    assign accept_c   = S_AXIS_TVALID && tready_c;
    assign cnt_last_c = (beat_cnt_q == BCW'(BPL - 1));
    assign line_end_c = S_AXIS_TLAST || cnt_last_c;

    axis2fifo_lane_pack #(
        .DW (AXIS_DATA_WIDTH)
    ) u_lane_pack (
        .part   (part_q),
        .data   (S_AXIS_TDATA),
        .strb   (S_AXIS_TSTRB),
        .idx    (beat_idx_q),
        .word_c (word_c)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        beat_cnt_d = beat_cnt_q;
        part_d     = part_q;
        vld_d      = vld_q && !fwr_rdy;
        dout_d     = dout_q;
        line_d     = line_q;
        frame_d    = 1'b0;
        err_d      = err_q;
        case (state_q)
            SYNC: begin
                if (accept_c && S_AXIS_TLAST) state_d = RUN;
            end
            RUN: begin
                if (accept_c) begin
                    part_d     = word_c;
                    beat_idx_d = S_AXIS_TLAST ? '0 : IDXW'(beat_idx_q + 1'b1);
                    beat_cnt_d = line_end_c ? '0 : BCW'(beat_cnt_q + 1'b1);
                    if ((beat_idx_q == IDXW'(LANES - 1)) || S_AXIS_TLAST) begin
                        vld_d  = 1'b1;
                        dout_d = word_c;
                    end
                    if (S_AXIS_TLAST != cnt_last_c) err_d = 1'b1;
                    if (line_end_c) begin
                        line_d  = (line_q == LINE_LAST) ? '0 : 11'(line_q + 11'd1);
                        frame_d = (line_q == LINE_LAST);
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SYNC;
            beat_idx_q <= '0;
            beat_cnt_q <= '0;
            part_q     <= '0;
            vld_q      <= 1'b0;
            dout_q     <= '0;
            line_q     <= '0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            beat_cnt_q <= beat_cnt_d;
            part_q     <= part_d;
            vld_q      <= vld_d;
            dout_q     <= dout_d;
            line_q     <= line_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            rdy_en_q   <= 1'b1;
        end
    end

    assign S_AXIS_TREADY = tready_c;
    assign fwr_vld       = vld_q;
    assign fwr_dout      = dout_q;
    assign line_cnt      = line_q;
    assign frame_done    = frame_q;
    assign err_tlast     = err_q;

endmodule

// File: tb/tb_axis2fifo.sv
// Directed bench for axis2fifo with a short frame geometry (32 beats per line, 6 lines per frame).
module tb_axis2fifo;

    localparam int unsigned FDW = 128;
    localparam int unsigned FAW = 8;
    localparam int unsigned ADW = 32;
    localparam int unsigned PH  = 128;
    localparam int unsigned PV  = 6;

`ifdef AXIS2FIFO_TSTRB_MASK_EN
    localparam logic [31:0] STRB_LANE = 32'h00BB00DD;
`else
    localparam logic [31:0] STRB_LANE = 32'hAABBCCDD;
`endif

    logic           clk;
    logic           rst_n;
    logic           tvalid;
    logic           tready;
    logic [31:0]    tdata;
    logic [3:0]     tstrb;
    logic           tlast;
    logic           fwr_vld;
    logic           fwr_rdy;
    logic [127:0]   fwr_dout;
    logic [FAW:0]   fwr_cnt;
    logic [10:0]    line_cnt;
    logic           frame_done;
    logic           err_tlast;

    int             n_checks = 0;
    int             n_pass   = 0;
    int             n_frame  = 0;
    int             rd_idx   = 0;
    int             first_stall;
    logic [127:0]   got_q[$];
    logic [127:0]   exp_q[$];
    logic           stalled_prev;
    logic [127:0]   dout_prev;

    axis2fifo #(
        .FDW               (FDW),
        .FAW               (FAW),
        .AXIS_DATA_WIDTH   (ADW),
        .PIXELS_HORIZONTAL (PH),
        .PIXELS_VERTICAL   (PV)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .S_AXIS_TVALID  (tvalid),
        .S_AXIS_TREADY  (tready),
        .S_AXIS_TDATA   (tdata),
        .S_AXIS_TSTRB   (tstrb),
        .S_AXIS_TLAST   (tlast),
        .fwr_vld        (fwr_vld),
        .fwr_rdy        (fwr_rdy),
        .fwr_dout       (fwr_dout),
        .fwr_cnt        (fwr_cnt),
        .line_cnt       (line_cnt),
        .frame_done     (frame_done),
        .err_tlast      (err_tlast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Called at a falling edge; returns at the falling edge after the beat was taken.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l, output int waited);
        waited = 0;
        tvalid = 1'b1;
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        #1;
        while (!tready && waited < 500) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!tready) check("tready_timeout", 128'(tready), 128'd1);
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_range(input logic [31:0] first, input int n, input bit last_final);
        int w;
        for (int k = 0; k < n; k++) begin
            send_beat(first + 32'(k), 4'hF, 1'(last_final && (k == n - 1)), w);
        end
    endtask

    task automatic push_words(input logic [31:0] first, input int nw);
        for (int i = 0; i < nw; i++) begin
            logic [31:0] b;
            b = first + 32'(4 * i);
            exp_q.push_back({b, b + 32'd1, b + 32'd2, b + 32'd3});
        end
    endtask

    task automatic check_words(input string tag);
        int avail;
        repeat (3) @(negedge clk);
        avail = got_q.size() - rd_idx;
        check({tag, "_count"}, 128'(avail), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < avail; i++) begin
            check({tag, "_word"}, got_q[rd_idx + i], exp_q[i]);
        end
        rd_idx = got_q.size();
        exp_q.delete();
    endtask

    // FIFO side observer: records transferred words, frame pulses and output stability under stall.
    initial begin
        stalled_prev = 1'b0;
        dout_prev    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (stalled_prev && fwr_vld) check("dout_stable", fwr_dout, dout_prev);
            if (fwr_vld && fwr_rdy) got_q.push_back(fwr_dout);
            if (frame_done) n_frame++;
            stalled_prev = fwr_vld && !fwr_rdy;
            dout_prev    = fwr_dout;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int frame_base;
        rst_n   = 1'b1;
        tvalid  = 1'b0;
        tdata   = '0;
        tstrb   = '0;
        tlast   = 1'b0;
        fwr_rdy = 1'b1;
        fwr_cnt = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tready", 128'(tready), 128'd0);
        check("rst_vld", 128'(fwr_vld), 128'd0);
        check("rst_line", 128'(line_cnt), 128'd0);
        check("rst_frame", 128'(frame_done), 128'd0);
        check("rst_err", 128'(err_tlast), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("sync_tready", 128'(tready), 128'd1);

        // Alignment line is discarded
        send_range(32'd1, 7, 1'b1);
        check("sync_vld", 128'(fwr_vld), 128'd0);
        check_words("sync");

        // First real line: latency and packing order
        send_range(32'd1, 3, 1'b0);
        check("lat_pre", 128'(fwr_vld), 128'd0);
        send_range(32'd4, 1, 1'b0);
        check("lat_vld", 128'(fwr_vld), 128'd1);
        check("word0", fwr_dout, 128'h00000001_00000002_00000003_00000004);
        send_range(32'd5, 28, 1'b1);
        push_words(32'd1, 8);
        check_words("line_a");
        check("line_a_cnt", 128'(line_cnt), 128'd1);
        check("line_a_err", 128'(err_tlast), 128'd0);

        // Back-pressure for 20 cycles mid-line
        first_stall = -1;
        for (int k = 0; k < 32; k++) begin
            if (k == 10) begin
                fwr_rdy = 1'b0;
                fork
                    begin
                        repeat (20) @(negedge clk);
                        fwr_rdy = 1'b1;
                    end
                join_none
            end
            send_beat(32'h100 + 32'(k), 4'hF, 1'(k == 31), w);
            if (w > 0 && first_stall < 0) first_stall = k;
        end
        check("stall_pos", 128'(first_stall), 128'd15);
        push_words(32'h100, 8);
        check_words("stall");
        check("stall_line", 128'(line_cnt), 128'd2);
        check("err_pre", 128'(err_tlast), 128'd0);

        // Early TLAST on the 7th beat
        send_range(32'h200, 7, 1'b1);
        exp_q.push_back({32'h200, 32'h201, 32'h202, 32'h203});
        exp_q.push_back({32'h204, 32'h205, 32'h206, 32'h0});
        check_words("early");
        check("early_err", 128'(err_tlast), 128'd1);
        check("early_line", 128'(line_cnt), 128'd3);
        send_range(32'h300, 32, 1'b1);
        push_words(32'h300, 8);
        check_words("after_early");
        check("after_early_line", 128'(line_cnt), 128'd4);

        // Reset with a pending word and a partial word
        fwr_rdy = 1'b0;
        send_range(32'h500, 5, 1'b0);
        check("pend_vld", 128'(fwr_vld), 128'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_vld", 128'(fwr_vld), 128'd0);
        check("rst_mid_err", 128'(err_tlast), 128'd0);
        check("rst_mid_line", 128'(line_cnt), 128'd0);
        check("rst_mid_tready", 128'(tready), 128'd0);
        fwr_rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_range(32'h600, 3, 1'b1);
        check_words("rst_drop");

        // 64 beats with TLAST only at the end: missing TLAST at beat 32
        send_range(32'h700, 64, 1'b1);
        push_words(32'h700, 16);
        check_words("no_tlast");
        check("no_tlast_err", 128'(err_tlast), 128'd1);
        check("no_tlast_line", 128'(line_cnt), 128'd2);

        // Remaining lines of the frame, including a strobe-qualified beat
        frame_base = n_frame;
        send_range(32'h900, 32, 1'b1);
        push_words(32'h900, 8);
        check_words("frame_l3");
        send_beat(32'hAABBCCDD, 4'b0101, 1'b0, w);
        send_range(32'h801, 31, 1'b1);
        exp_q.push_back({STRB_LANE, 32'h801, 32'h802, 32'h803});
        push_words(32'h804, 7);
        check_words("strb");
        send_range(32'hA00, 32, 1'b1);
        push_words(32'hA00, 8);
        check_words("frame_l5");
        check("pre_wrap_line", 128'(line_cnt), 128'd5);
        check("pre_wrap_frames", 128'(n_frame - frame_base), 128'd0);
        send_range(32'hB00, 31, 1'b0);
        send_beat(32'hB1F, 4'hF, 1'b1, w);
        check("wrap_pulse", 128'(frame_done), 128'd1);
        check("wrap_line", 128'(line_cnt), 128'd0);
        @(negedge clk);
        check("wrap_pulse_end", 128'(frame_done), 128'd0);
        push_words(32'hB00, 8);
        check_words("frame_last");
        check("wrap_frames", 128'(n_frame - frame_base), 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
